twos_comp_serial_tx: RTL

TWOS_COMP_SERIAL_TX -- requirements
Module: twos_comp_serial_tx

---
 rtl/twos_comp_serial_tx.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/twos_comp_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : twos_comp_serial_tx
// Purpose  : Accepts a WIDTH-bit word and serially transmits its two's
//            complement LSB first. It copies source bits up to and including
//            the first 1, then inverts every following source bit.
//            Optional feature macro TWOS_TX_PARITY_EN appends one even-parity
//            bit (XOR of the transmitted data bits) as the final frame bit.
// Ports    : clk        - sole clock, rising edge
//            reset      - synchronous, active-high reset
//            load_valid - parallel word offered
//            load_data  - word to transmit (WIDTH bits)
//            load_ready - word can be accepted this cycle
//            dout       - serial bit, LSB first (registered)
//            dout_valid - dout carries a frame bit (registered)
//            last       - final bit of the frame (registered)
//            ovf        - input was the most-negative value; valid with last
// Revision : 1.0 - initial release
// ============================================================================
module twos_comp_serial_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             last,
    output logic             ovf
);

    localparam int c_cnt_w = $clog2(WIDTH);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_copy   = 2'd1;
    localparam logic [1:0] c_invert = 2'd2;
`ifdef TWOS_TX_PARITY_EN
    localparam logic [1:0] c_par    = 2'd3;
`endif

    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
`ifndef TWOS_TX_PARITY_EN
    localparam logic [c_cnt_w-1:0] c_cnt_pen  = c_cnt_w'(WIDTH - 2);
`endif
    localparam logic [WIDTH-1:0]   c_min_neg  = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_shift;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_dout;
    logic               r_dout_valid;
    logic               r_last;
    logic               r_ovf;
    logic               r_min_neg;
`ifdef TWOS_TX_PARITY_EN
    logic               r_par;
`endif

    logic               w_inv;
    logic               w_next_bit;

    // r_shift[0] is the source bit currently on dout. Once it (or an earlier
    // bit) was a 1, every following bit is inverted.
    assign w_inv      = (r_state == c_invert) || r_shift[0];
    assign w_next_bit = w_inv ? ~r_shift[1] : r_shift[1];

    assign load_ready = (r_state == c_idle) && !reset;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign last       = r_last;
    assign ovf        = r_ovf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_idle;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_dout       <= 1'b0;
            r_dout_valid <= 1'b0;
            r_last       <= 1'b0;
            r_ovf        <= 1'b0;
            r_min_neg    <= 1'b0;
`ifdef TWOS_TX_PARITY_EN
            r_par        <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_idle: begin
                    r_dout       <= 1'b0;
                    r_dout_valid <= 1'b0;
                    r_last       <= 1'b0;
                    r_ovf        <= 1'b0;
                    if (load_valid) begin
                        // Bit 0 of the result always equals source bit 0, so
                        // it is launched straight from the input word.
                        r_state      <= c_copy;
                        r_shift      <= load_data;
                        r_cnt        <= '0;
                        r_dout       <= load_data[0];
                        r_dout_valid <= 1'b1;
                        r_min_neg    <= (load_data == c_min_neg);
`ifdef TWOS_TX_PARITY_EN
                        r_par        <= load_data[0];
`endif
                    end
                end

                c_copy, c_invert: begin
                    if (r_cnt == c_cnt_last) begin
`ifdef TWOS_TX_PARITY_EN
                        r_state      <= c_par;
                        r_dout       <= r_par;
                        r_dout_valid <= 1'b1;
                        r_last       <= 1'b1;
                        r_ovf        <= r_min_neg;
`else
                        r_state      <= c_idle;
                        r_dout       <= 1'b0;
                        r_dout_valid <= 1'b0;
                        r_last       <= 1'b0;
                        r_ovf        <= 1'b0;
`endif
                    end else begin
                        r_state      <= w_inv ? c_invert : c_copy;
                        r_shift      <= {1'b0, r_shift[WIDTH-1:1]};
                        r_cnt        <= r_cnt + 1'b1;
                        r_dout       <= w_next_bit;
                        r_dout_valid <= 1'b1;
`ifdef TWOS_TX_PARITY_EN
                        r_par        <= r_par ^ w_next_bit;
                        r_last       <= 1'b0;
                        r_ovf        <= 1'b0;
`else
                        r_last       <= (r_cnt == c_cnt_pen);
                        r_ovf        <= (r_cnt == c_cnt_pen) && r_min_neg;
`endif
                    end
                end

`ifdef TWOS_TX_PARITY_EN
                c_par: begin
                    r_state      <= c_idle;
                    r_dout       <= 1'b0;
                    r_dout_valid <= 1'b0;
                    r_last       <= 1'b0;
                    r_ovf        <= 1'b0;
                end
`endif

                default: begin
                    r_state      <= c_idle;
                    r_dout       <= 1'b0;
                    r_dout_valid <= 1'b0;
                    r_last       <= 1'b0;
                    r_ovf        <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
